vend_change_dispenser: RTL and testbench

- Payout-side counterpart to the coin-acceptor inputs of the vending FSM. The FSM's inputs count coins in; this block pays coins out.
- On a payout request carrying an amount in ₹5 units, it drives a two-chute coin hopper (₹10 and ₹5) one coin at a time with a hold-until-ack handshake.
- Prefers ₹10 coins, falls back to ₹5 when the ₹10 tube is empty, and flags a fault if the hopper stops responding.
- Sits between the vending FSM's refund/change path and the hopper driver.

---
 rtl/vend_change_dispenser.sv | 130 +++++++++++++
 tb/tb_vend_change_dispenser.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/vend_change_dispenser.sv
// vend_change_dispenser: pays out a requested amount (in Rs5 units) through a
// two-chute hopper, one coin at a time, with a hold-until-ack handshake.
// Prefers Rs10 coins and falls back to Rs5 when the Rs10 tube is empty.
// A coin that is not acked within ACK_TIMEOUT cycles parks the block in FAULT.
// Optional: define VEND_CHANGE_TALLY_EN to add saturating per-denomination
// tallies of acked coins (tally_10 / tally_5).
module vend_change_dispenser #(
    parameter int UNITS_W     = 6,
    parameter int GAP_CYC     = 2,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req,
    input  logic [UNITS_W-1:0] units,
    input  logic               empty_10,
    input  logic               hopper_ack,
    input  logic               fault_clr,
    output logic               eject_10,
    output logic               eject_5,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [UNITS_W-1:0] remaining
`ifdef VEND_CHANGE_TALLY_EN
    ,
    output logic [15:0]        tally_10,
    output logic [15:0]        tally_5
`endif
);

    localparam int CNT_MAX = (ACK_TIMEOUT > GAP_CYC) ? ACK_TIMEOUT : GAP_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SELECT, S_WAIT_ACK, S_GAP, S_DONE, S_FAULT
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;       // shared: ack timeout in WAIT_ACK, settle count in GAP
    logic             coin_10;   // denomination of the coin in flight
    logic             sel_10;
    logic             timeout;
    logic             gap_end;

    // State register; reset aborts any payout immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state and Moore outputs; ejects are driven only from WAIT_ACK so they never overlap
    always_comb begin
        state_nxt = state;
        sel_10    = 1'b0;
        timeout   = (cnt == CNT_W'(ACK_TIMEOUT - 1));
        gap_end   = (cnt == CNT_W'(GAP_CYC - 1));
        eject_10  = (state == S_WAIT_ACK) &&  coin_10;
        eject_5   = (state == S_WAIT_ACK) && !coin_10;
        busy      = (state != S_IDLE);
        done      = (state == S_DONE);
        error     = (state == S_FAULT);
        case (state)
            S_IDLE:     if (req) state_nxt = (units == '0) ? S_DONE : S_SELECT;
            S_SELECT: begin
                if (remaining >= UNITS_W'(2) && !empty_10) begin
                    sel_10    = 1'b1;
                    state_nxt = S_WAIT_ACK;
                end else if (remaining != '0) begin
                    state_nxt = S_WAIT_ACK;
                end else begin
                    state_nxt = S_DONE;
                end
            end
            // ack is checked first so an ack on the final timeout cycle still counts
            S_WAIT_ACK: begin
                if (hopper_ack)   state_nxt = S_GAP;
                else if (timeout) state_nxt = S_FAULT;
            end
            S_GAP:      if (gap_end) state_nxt = S_SELECT;
            S_DONE:     state_nxt = S_IDLE;
            S_FAULT:    if (fault_clr) state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    // Datapath: amount latch, coin choice (frozen for the whole WAIT_ACK), counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            remaining <= '0;
            cnt       <= '0;
            coin_10   <= 1'b0;
        end else begin
            case (state)
                S_IDLE:   if (req) remaining <= units;
                S_SELECT: begin
                    coin_10 <= sel_10;
                    cnt     <= '0;
                end
                S_WAIT_ACK: begin
                    if (hopper_ack) begin
                        remaining <= remaining - (coin_10 ? UNITS_W'(2) : UNITS_W'(1));
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_GAP:    cnt <= cnt + 1'b1;
                S_FAULT:  if (fault_clr) remaining <= '0;
                default:  ;
            endcase
        end
    end

`ifdef VEND_CHANGE_TALLY_EN
    // Saturating counts of acked coins per denomination; cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tally_10 <= '0;
            tally_5  <= '0;
        end else if (state == S_WAIT_ACK && hopper_ack) begin
            if (coin_10  && tally_10 != 16'hFFFF) tally_10 <= tally_10 + 16'd1;
            if (!coin_10 && tally_5  != 16'hFFFF) tally_5  <= tally_5 + 16'd1;
        end
    end
`else
    // No tally counters in this build.
`endif

endmodule

// File: tb/tb_vend_change_dispenser.sv
// Bench for vend_change_dispenser: table of payouts checked against a coin
// scoreboard, plus hand sequences for timeout, ack-at-timeout, duplicate req
// and asynchronous reset.
module tb_vend_change_dispenser;

    localparam int UW  = 6;
    localparam int GAP = 2;
    localparam int TO  = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          req;
    logic [UW-1:0] units;
    logic          empty_10;
    logic          hopper_ack;
    logic          fault_clr;
    logic          eject_10, eject_5, busy, done, error;
    logic [UW-1:0] remaining;
`ifdef VEND_CHANGE_TALLY_EN
    logic [15:0]   tally_10, tally_5;
`endif

    vend_change_dispenser #(.UNITS_W(UW), .GAP_CYC(GAP), .ACK_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .units(units), .empty_10(empty_10),
        .hopper_ack(hopper_ack), .fault_clr(fault_clr),
        .eject_10(eject_10), .eject_5(eject_5), .busy(busy), .done(done),
        .error(error), .remaining(remaining)
`ifdef VEND_CHANGE_TALLY_EN
        , .tally_10(tally_10), .tally_5(tally_5)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int exp_q[$];
    int t10 = 0, t5 = 0;

    typedef struct {
        int units;
        bit empty;
        bit dup;
        int n10;
        int n5;
    } vec_t;
    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // One payout with a hopper that acks on the second cycle of each eject.
    task automatic run_payout(input int u, input bit e, input bit dup, output int n10, output int n5);
        int rem, hi, low_run, ovl, coin;
        bit fin, first;
        exp_q.delete();
        rem = u;
        while (rem > 0) begin
            if (rem >= 2 && !e) begin exp_q.push_back(10); rem -= 2; end
            else                begin exp_q.push_back(5);  rem -= 1; end
        end
        rem = u; n10 = 0; n5 = 0; hi = 0; low_run = 0; ovl = 0; fin = 0; first = 1;
        @(negedge clk); req = 1'b1; units = UW'(u); empty_10 = e;
        @(negedge clk); req = 1'b0;
        for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
            if (eject_10 && eject_5) ovl++;
            if (eject_10 || eject_5) begin
                if (hi == 0) begin
                    coin = eject_10 ? 10 : 5;
                    if (eject_10) n10++; else n5++;
                    if (exp_q.size() == 0) check("extra_coin", coin, 0);
                    else                   check("coin_seq", coin, exp_q.pop_front());
                    check("remaining_pre_coin", remaining, rem);
                    rem -= (coin == 10) ? 2 : 1;
                    if (!first) check("gap_len_ok", low_run >= GAP, 1);
                    first = 0;
                    if (dup) begin req = 1'b1; units = UW'(5); end
                end else begin
                    req = 1'b0;
                end
                hi++; low_run = 0;
                hopper_ack = (hi == 2);
            end else begin
                hi = 0; low_run++; hopper_ack = 1'b0; req = 1'b0;
            end
            if (done) fin = 1;
            @(negedge clk);
        end
        hopper_ack = 1'b0; req = 1'b0;
        check("done_seen", fin, 1);
        check("scoreboard_empty", exp_q.size(), 0);
        check("remaining_end", remaining, 0);
        check("no_overlap", ovl, 0);
        check("done_one_cycle", done, 0);
        check("busy_end", busy, 0);
        t10 += n10; t5 += n5;
    endtask

    task automatic wait_eject(input string name, output bit ok);
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (eject_10 || eject_5) ok = 1;
            else @(negedge clk);
        end
        check(name, ok, 1);
    endtask

    initial begin
        int n10, n5, hc;
        bit ok;
        vecs[0] = '{units: 5, empty: 0, dup: 0, n10: 2, n5: 1};
        vecs[1] = '{units: 4, empty: 1, dup: 0, n10: 0, n5: 4};
        vecs[2] = '{units: 0, empty: 0, dup: 0, n10: 0, n5: 0};
        vecs[3] = '{units: 2, empty: 0, dup: 1, n10: 1, n5: 0};
        vecs[4] = '{units: 6, empty: 0, dup: 0, n10: 3, n5: 0};
        vecs[5] = '{units: 1, empty: 0, dup: 0, n10: 0, n5: 1};
        vecs[6] = '{units: 3, empty: 1, dup: 0, n10: 0, n5: 3};

        rst = 1'b1; req = 1'b0; units = '0; empty_10 = 1'b0; hopper_ack = 1'b0; fault_clr = 1'b0;
        @(negedge clk); @(negedge clk);
        check("rst_outputs", {eject_10, eject_5, busy, done, error}, 0);
        check("rst_remaining", remaining, 0);
        rst = 1'b0;
        @(negedge clk);

        // stray ack in IDLE is ignored
        hopper_ack = 1'b1; @(negedge clk); hopper_ack = 1'b0; @(negedge clk);
        check("idle_ack_busy", busy, 0);
        check("idle_ack_remaining", remaining, 0);

        // units = 0: done on the cycle after req
        @(negedge clk); req = 1'b1; units = '0;
        @(negedge clk); req = 1'b0;
        check("zero_done_next_cycle", done, 1);
        check("zero_no_eject", {eject_10, eject_5}, 0);
        @(negedge clk);

        foreach (vecs[i]) begin
            run_payout(vecs[i].units, vecs[i].empty, vecs[i].dup, n10, n5);
            check("vec_n10", n10, vecs[i].n10);
            check("vec_n5", n5, vecs[i].n5);
        end

        // no ack: eject_10 held ACK_TIMEOUT cycles, then FAULT
        @(negedge clk); req = 1'b1; units = UW'(3); empty_10 = 1'b0;
        @(negedge clk); req = 1'b0;
        wait_eject("to_eject_seen", ok);
        hc = 0;
        while (eject_10 && hc < 40) begin hc++; @(negedge clk); end
        check("timeout_hold_cycles", hc, TO);
        check("timeout_error", error, 1);
        check("timeout_busy", busy, 1);
        check("timeout_remaining", remaining, 3);
        req = 1'b1; units = UW'(2);
        @(negedge clk); req = 1'b0; @(negedge clk);
        check("fault_req_ignored_err", error, 1);
        check("fault_req_ignored_rem", remaining, 3);
        check("fault_ejects_low", {eject_10, eject_5}, 0);
        fault_clr = 1'b1; @(negedge clk); fault_clr = 1'b0;
        check("clr_error", error, 0);
        check("clr_busy", busy, 0);
        check("clr_remaining", remaining, 0);

        // ack on the last timeout cycle wins
        @(negedge clk); req = 1'b1; units = UW'(1);
        @(negedge clk); req = 1'b0;
        wait_eject("edge_eject_seen", ok);
        for (int k = 2; k <= TO; k++) @(negedge clk);
        check("edge_eject_still_high", eject_5, 1);
        hopper_ack = 1'b1; @(negedge clk); hopper_ack = 1'b0;
        check("edge_no_error", error, 0);
        check("edge_remaining", remaining, 0);
        check("edge_eject_dropped", eject_5, 0);
        t5++;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (done) ok = 1; else @(negedge clk);
        end
        check("edge_done", ok, 1);
        @(negedge clk);

`ifdef VEND_CHANGE_TALLY_EN
        check("tally_10", tally_10, t10);
        check("tally_5", tally_5, t5);
`endif

        // asynchronous reset during WAIT_ACK
        @(negedge clk); req = 1'b1; units = UW'(2); empty_10 = 1'b0;
        @(negedge clk); req = 1'b0;
        wait_eject("rst_eject_seen", ok);
        #2 rst = 1'b1;
        #1;
        check("async_rst_outputs", {eject_10, eject_5, busy, done, error}, 0);
        check("async_rst_remaining", remaining, 0);
`ifdef VEND_CHANGE_TALLY_EN
        check("async_rst_tally", {tally_10, tally_5}, 0);
`endif
        @(negedge clk); rst = 1'b0; @(negedge clk);
        check("post_rst_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
